mem_stage_v3: RTL and testbench
===============================

# mem_stage_v3

Parametrised memory-access stage for the 4-stage MIPS pipeline, sitting between execute and write-back. It registers the EX results and performs loads and stores against an internal byte-addressed data memory, with byte, halfword and word accesses and sign or zero extension. A configurable number of wait states is applied to memory ops, and a stall signal holds the upstream stage while an op is in flight. Misaligned accesses are flagged.

## Interface
- SIZE, 32: data and address width; only 32 is supported (4 byte lanes).
- DEPTH, 32: data memory words; power of 2, ≥2; AW = $clog2(DEPTH).
- MEM_LAT, 1: cycles per memory op, 1..8; non-memory ops always take 1.
- CTRL_W, 11: width of the control bundle passed through.
- TEST_ADDR, 4: word index exposed on testMem.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_EX  in  1  EX stage presents an instruction.
- ALUresult  in  SIZE  byte address for memory ops; the result for other ops.
- storeData_EX  in  SIZE  store data; low bits are used for byte and halfword stores.
- mem_read_EX, mem_write_EX  in  1 each  load or store request.
- size_EX  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- unsigned_EX  in  1  zero-extend loads (lbu/lhu) when high.
- writeReg_EX  in  $clog2(SIZE)  destination register.
- control_EX  in  CTRL_W  control bundle.
- ALUresult_MEM  out  SIZE  load data, or the passed-through ALUresult.
- writeReg_MEM  out  $clog2(SIZE); control_MEM  out  CTRL_W.
- valid_MEM  out  1  outputs hold a completed instruction (one-cycle pulse per instruction).
- err_MEM  out  1  completed op was misaligned or had both read and write set.
- stall_MEM  out  1  upstream must hold its inputs.
- testMem  out  SIZE  combinational view of memory word TEST_ADDR.

## Operation
- Address decode:
  - Word index = ALUresult[AW+1:2]; higher bits are ignored, so addresses wrap modulo 4·DEPTH.
  - Byte lane = ALUresult[1:0].
- Memory init: word i = i at time zero. Memory is not cleared by reset.
- FSM states: IDLE and BUSY. BUSY holds a latched op and a down-counter cnt.
- IDLE, valid_EX = 0:
  - valid_MEM <= 0.
  - Other outputs hold their values.
- IDLE, valid_EX = 1, non-memory op:
  - ALUresult_MEM <= ALUresult.
  - writeReg_MEM and control_MEM <= the EX values.
  - valid_MEM <= 1, err_MEM <= 0.
- IDLE, valid_EX = 1, memory op, MEM_LAT = 1: the op completes at this edge, as in "Completion" below.
- IDLE, valid_EX = 1, memory op, MEM_LAT > 1:
  - Latch all inputs, set cnt <= MEM_LAT-1, move to BUSY.
  - valid_MEM <= 0.
- BUSY:
  - EX inputs are ignored.
  - If cnt > 1: cnt decrements.
  - If cnt == 1: complete the latched op and return to IDLE.
- Completion:
  - writeReg_MEM and control_MEM are updated.
  - valid_MEM <= 1.
- Completion, load: ALUresult_MEM <= the selected lane(s), extended.
  - Byte: lane ALUresult[1:0], bits 7:0 of the result.
  - Halfword: lanes [1:0] or [3:2] selected by ALUresult[1].
  - Sign extension unless unsigned_EX is high.
- Completion, store:
  - Only the addressed lanes are written, from storeData[7:0], [15:0] or [31:0]; other lanes are untouched.
  - ALUresult_MEM <= address.
- Error cases, each setting err_MEM <= 1:
  - Misaligned: halfword with ALUresult[0] = 1, or word with ALUresult[1:0] ≠ 0. No memory write occurs and ALUresult_MEM <= 0.
  - mem_read_EX and mem_write_EX both high: no memory action, and ALUresult_MEM <= ALUresult.
- stall_MEM = (state == BUSY), combinational from the registered state.

## Timing
- Reset (rst_n low, takes effect immediately):
  - State = IDLE, cnt = 0.
  - ALUresult_MEM, writeReg_MEM, control_MEM, valid_MEM, err_MEM all 0.
  - stall_MEM = 0.
- Reset during BUSY: the pending op is discarded, so a pending store never writes memory.
- Non-memory op: result visible after the capture edge (1 cycle).
- Memory op: result visible after the MEM_LAT-th edge, counting the capture edge as edge 1.
  - stall_MEM is high for MEM_LAT-1 cycles, starting after the capture edge.
  - The next instruction is accepted at edge MEM_LAT+1.
- Upstream rule: while stall_MEM = 1, valid_EX and all EX inputs must be held stable. The held instruction is accepted at the first edge with stall_MEM = 0.
- A load issued right after a store to the same word reads the updated data, because the write is committed at the store's completion edge.
- testMem reflects a store in the same cycle as that store's completion edge.

## Test plan
- Reset: hold rst_n low mid-cycle → all outputs 0 immediately; testMem = 0x00000004.
- MEM_LAT = 1, lw at address 0x10 → next edge: ALUresult_MEM = 0x00000004, valid_MEM = 1, stall_MEM never high.
- sb 0x000000AB at address 0x11, then lbu and lb at 0x11:
  - testMem = 0x0000AB04.
  - lbu returns 0x000000AB; lb returns 0xFFFFFFAB.
- MEM_LAT = 3, lw at 0x0C followed by an add:
  - stall_MEM high for 2 cycles, valid_MEM = 0.
  - Result 0x00000003 after the 3rd edge.
  - The add is accepted at the 4th edge.
- lh at 0x13 and sw at 0x22:
  - Each gives err_MEM = 1.
  - lh gives ALUresult_MEM = 0.
  - Memory words 4 and 8 are unchanged.
- MEM_LAT = 4: sw 0xDEADBEEF to 0x10, assert rst_n after 2 cycles → testMem stays 0x00000004; FSM is IDLE after release.

Source files
------------

// File: rtl/mem_stage_v3_if.sv
// mem_stage_v3_if: EX -> MEM bundle for the memory-access stage.
//   master : upstream/execute side, drives the *_EX request fields and
//            observes the registered *_MEM results and stall_MEM.
//   slave  : the memory stage itself.
// Signals:
//   valid_EX, ALUresult, storeData_EX, mem_read_EX, mem_write_EX,
//   size_EX, unsigned_EX, writeReg_EX, control_EX        (EX request)
//   ALUresult_MEM, writeReg_MEM, control_MEM, valid_MEM,
//   err_MEM, stall_MEM                                    (MEM result)
interface mem_stage_v3_if #(
  parameter int SIZE   = 32,
  parameter int CTRL_W = 11
);
  logic                    valid_EX;
  logic [SIZE-1:0]         ALUresult;
  logic [SIZE-1:0]         storeData_EX;
  logic                    mem_read_EX;
  logic                    mem_write_EX;
  logic [1:0]              size_EX;
  logic                    unsigned_EX;
  logic [$clog2(SIZE)-1:0] writeReg_EX;
  logic [CTRL_W-1:0]       control_EX;

  logic [SIZE-1:0]         ALUresult_MEM;
  logic [$clog2(SIZE)-1:0] writeReg_MEM;
  logic [CTRL_W-1:0]       control_MEM;
  logic                    valid_MEM;
  logic                    err_MEM;
  logic                    stall_MEM;

  modport master (
    output valid_EX, ALUresult, storeData_EX, mem_read_EX, mem_write_EX,
           size_EX, unsigned_EX, writeReg_EX, control_EX,
    input  ALUresult_MEM, writeReg_MEM, control_MEM, valid_MEM, err_MEM,
           stall_MEM
  );

  modport slave (
    input  valid_EX, ALUresult, storeData_EX, mem_read_EX, mem_write_EX,
           size_EX, unsigned_EX, writeReg_EX, control_EX,
    output ALUresult_MEM, writeReg_MEM, control_MEM, valid_MEM, err_MEM,
           stall_MEM
  );
endinterface

// File: rtl/mem_stage_v3.sv
// mem_stage_v3: memory-access stage of the 4-stage MIPS pipeline.
// Registers EX results and performs byte/halfword/word loads and stores
// (sign or zero extended) on an internal byte-addressed data memory, with
// MEM_LAT cycles per memory op; stall_MEM holds upstream while busy.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : mem_stage_v3_if.slave (EX request in, MEM result out)
//   testMem    : combinational view of memory word TEST_ADDR
module mem_stage_v3 #(
  parameter int SIZE      = 32,
  parameter int DEPTH     = 32,
  parameter int MEM_LAT   = 1,
  parameter int CTRL_W    = 11,
  parameter int TEST_ADDR = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_stage_v3_if.slave   bus,
  output logic [SIZE-1:0] testMem
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(SIZE);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  // Power-up image: word i holds i. Reset never touches the array.
  function automatic logic [DEPTH*SIZE-1:0] mem_image();
    logic [DEPTH*SIZE-1:0] img;
    img = '0;
    for (int unsigned i = 0; i < DEPTH; i++) img[i*SIZE +: SIZE] = SIZE'(i);
    return img;
  endfunction
  localparam logic [DEPTH*SIZE-1:0] MEM_INIT = mem_image();

  typedef struct packed {
    logic [SIZE-1:0]   addr;
    logic [SIZE-1:0]   sdata;
    logic              rd;
    logic              wr;
    logic [1:0]        size;
    logic              uns;
    logic [RW-1:0]     wreg;
    logic [CTRL_W-1:0] ctrl;
  } op_t;

  logic [DEPTH-1:0][SIZE-1:0] mem = MEM_INIT;

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  op_t               op_q, op_d;
  logic [SIZE-1:0]   alu_q, alu_d;
  logic [RW-1:0]     wreg_q, wreg_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  op_t               ex_op, op;
  logic [AW-1:0]     widx;
  logic [1:0]        lane;
  logic [SIZE-1:0]   rword, load_v, cmp_alu, mem_wdata;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [3:0]        mem_be;
  logic              is_byte, is_half, misal, conflict, cmp_err, complete, mem_we;

  always_comb begin
    ex_op = '{addr: bus.ALUresult, sdata: bus.storeData_EX, rd: bus.mem_read_EX,
              wr: bus.mem_write_EX, size: bus.size_EX, uns: bus.unsigned_EX,
              wreg: bus.writeReg_EX, ctrl: bus.control_EX};
  end

  // While BUSY the latched op is the one being executed; EX is ignored.
  assign op = (state_q == ST_BUSY) ? op_q : ex_op;

  always_comb begin
    widx     = op.addr[AW+1:2];
    lane     = op.addr[1:0];
    rword    = mem[widx];
    is_byte  = (op.size == 2'b00);
    is_half  = (op.size == 2'b01);
    misal    = (is_half && lane[0]) || (!is_byte && !is_half && lane != 2'b00);
    conflict = op.rd && op.wr;

    byte_v = rword[{lane, 3'b000} +: 8];
    half_v = lane[1] ? rword[31:16] : rword[15:0];
    if (is_byte)      load_v = {{24{~op.uns & byte_v[7]}}, byte_v};
    else if (is_half) load_v = {{16{~op.uns & half_v[15]}}, half_v};
    else              load_v = rword;

    if (is_byte) begin
      mem_be    = 4'b0001 << lane;
      mem_wdata = {4{op.sdata[7:0]}};
    end else if (is_half) begin
      mem_be    = lane[1] ? 4'b1100 : 4'b0011;
      mem_wdata = {2{op.sdata[15:0]}};
    end else begin
      mem_be    = 4'b1111;
      mem_wdata = op.sdata;
    end

    // Read+write conflict takes precedence over the misalignment result.
    if (conflict)   cmp_alu = op.addr;
    else if (misal) cmp_alu = '0;
    else if (op.rd) cmp_alu = load_v;
    else            cmp_alu = op.addr;
    cmp_err = conflict || misal;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    alu_d    = alu_q;
    wreg_d   = wreg_q;
    ctrl_d   = ctrl_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid_EX) begin
          if (!(bus.mem_read_EX || bus.mem_write_EX)) begin
            alu_d   = bus.ALUresult;
            wreg_d  = bus.writeReg_EX;
            ctrl_d  = bus.control_EX;
            valid_d = 1'b1;
            err_d   = 1'b0;
          end else if (MEM_LAT == 1) begin
            complete = 1'b1;
          end else begin
            op_d    = ex_op;
            cnt_d   = LAT_M1;
            state_d = ST_BUSY;
          end
        end
      end
      default: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end
      end
    endcase
    if (complete) begin
      alu_d   = cmp_alu;
      wreg_d  = op.wreg;
      ctrl_d  = op.ctrl;
      valid_d = 1'b1;
      err_d   = cmp_err;
    end
  end

  // rst_n gate keeps a store from committing on an edge seen during reset.
  assign mem_we = complete && op.wr && !cmp_err && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      alu_q   <= '0;
      wreg_q  <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      alu_q   <= alu_d;
      wreg_q  <= wreg_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  assign bus.ALUresult_MEM = alu_q;
  assign bus.writeReg_MEM  = wreg_q;
  assign bus.control_MEM   = ctrl_q;
  assign bus.valid_MEM     = valid_q;
  assign bus.err_MEM       = err_q;
  assign bus.stall_MEM     = (state_q == ST_BUSY);
  assign testMem           = mem[AW'(TEST_ADDR)];
endmodule

// File: tb/tb_mem_stage_v3.sv
// tb_mem_stage_v3: three instances (MEM_LAT = 1, 3, 4) share one stimulus
// bus; valid_EX reaches only the instance selected by 'sel'. Expected
// results come from a byte-level memory model kept per instance.
module tb_mem_stage_v3;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int          sel;
  logic        ex_valid, ex_rd, ex_wr, ex_uns;
  logic [1:0]  ex_size;
  logic [31:0] ex_alu, ex_sd;
  logic [4:0]  ex_wreg;
  logic [10:0] ex_ctrl;

  logic [31:0] o_alu [3];
  logic [31:0] o_tm  [3];
  logic [4:0]  o_wreg[3];
  logic [10:0] o_ctrl[3];
  logic        o_valid[3], o_err[3], o_stall[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage_v3_if #(.SIZE(32), .CTRL_W(11)) bus ();
    assign bus.valid_EX     = ex_valid && (sel == g);
    assign bus.ALUresult    = ex_alu;
    assign bus.storeData_EX = ex_sd;
    assign bus.mem_read_EX  = ex_rd;
    assign bus.mem_write_EX = ex_wr;
    assign bus.size_EX      = ex_size;
    assign bus.unsigned_EX  = ex_uns;
    assign bus.writeReg_EX  = ex_wreg;
    assign bus.control_EX   = ex_ctrl;
    assign o_alu[g]   = bus.ALUresult_MEM;
    assign o_wreg[g]  = bus.writeReg_MEM;
    assign o_ctrl[g]  = bus.control_MEM;
    assign o_valid[g] = bus.valid_MEM;
    assign o_err[g]   = bus.err_MEM;
    assign o_stall[g] = bus.stall_MEM;
    mem_stage_v3 #(
      .SIZE(32), .DEPTH(32), .MEM_LAT((g == 0) ? 1 : (g == 1) ? 3 : 4),
      .CTRL_W(11), .TEST_ADDR(4)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .testMem(o_tm[g])
    );
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mdl [3][32];
  logic [31:0] last_alu[3];
  logic        last_err[3];
  logic [31:0] got;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference behaviour of one completed op on the selected instance.
  task automatic model_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          output logic [31:0] res, output logic err);
    int     idx, lane, nb;
    longint v, span;
    idx  = int'((addr >> 2) % 32);
    lane = int'(addr % 4);
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    span = longint'(1) << (8 * nb);
    if (!rd && !wr) begin
      res = addr; err = 1'b0;
    end else if (rd && wr) begin
      res = addr; err = 1'b1;
    end else if (addr % nb != 0) begin
      res = 32'd0; err = 1'b1;
    end else if (rd) begin
      v = (longint'(mdl[sel][idx]) >> (8 * lane)) % span;
      if (!uns && nb < 4 && v >= span / 2) v = v - span;
      res = v[31:0]; err = 1'b0;
    end else begin
      for (int k = 0; k < nb; k++) mdl[sel][idx][8*(lane+k) +: 8] = sdata[8*k +: 8];
      res = addr; err = 1'b0;
    end
  endtask

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 3 : 4;
  endfunction

  task automatic run_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        output logic [31:0] res_o);
    logic [31:0] exp_res;
    logic        exp_err;
    logic [4:0]  w_r;
    logic [10:0] c_r;
    int          lat;
    lat = (rd || wr) ? lat_of(sel) : 1;
    w_r = 5'($urandom);
    c_r = 11'($urandom);
    model_op(rd, wr, sz, uns, addr, sdata, exp_res, exp_err);
    @(negedge clk);
    ex_valid = 1'b1; ex_rd = rd; ex_wr = wr; ex_size = sz; ex_uns = uns;
    ex_alu = addr; ex_sd = sdata; ex_wreg = w_r; ex_ctrl = c_r;
    for (int e = 1; e <= lat; e++) begin
      @(posedge clk); #1;
      if (e < lat) begin
        check_val("stall_busy", o_stall[sel], 1);
        check_val("valid_busy", o_valid[sel], 0);
      end
    end
    ex_valid = 1'b0;
    check_val("valid_done", o_valid[sel], 1);
    check_val("stall_done", o_stall[sel], 0);
    check_val("result", o_alu[sel], exp_res);
    check_val("err", o_err[sel], exp_err);
    check_val("wreg", o_wreg[sel], w_r);
    check_val("ctrl", o_ctrl[sel], c_r);
    check_val("testmem", o_tm[sel], mdl[sel][4]);
    last_alu[sel] = exp_res;
    last_err[sel] = exp_err;
    res_o = o_alu[sel];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_val("idle_valid", o_valid[sel], 0);
      check_val("idle_stall", o_stall[sel], 0);
      check_val("idle_hold", o_alu[sel], last_alu[sel]);
      check_val("idle_err", o_err[sel], last_err[sel]);
    end
  endtask

  task automatic check_reset_outputs(input int s);
    check_val("rst_alu", o_alu[s], 0);
    check_val("rst_wreg", o_wreg[s], 0);
    check_val("rst_ctrl", o_ctrl[s], 0);
    check_val("rst_valid", o_valid[s], 0);
    check_val("rst_err", o_err[s], 0);
    check_val("rst_stall", o_stall[s], 0);
  endtask

  task automatic clear_last();
    for (int s = 0; s < 3; s++) begin
      last_alu[s] = 32'd0;
      last_err[s] = 1'b0;
    end
  endtask

  initial begin
    bit rd, wr;
    int kind;
    logic [31:0] addr;
    rst_n = 1'b0; sel = 0; ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0;
    ex_size = 2'd0; ex_uns = 1'b0; ex_alu = '0; ex_sd = '0; ex_wreg = '0; ex_ctrl = '0;
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 32; i++) mdl[s][i] = 32'(i);
    clear_last();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs(0);
    check_val("init_testmem", o_tm[0], 32'h4);

    // MEM_LAT = 1 instance
    run_op(0, 0, 2'd2, 0, 32'h1234_5678, 32'd0, got);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    check_val("rst_testmem", o_tm[0], 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    clear_last();
    run_op(1, 0, 2'd2, 0, 32'h10, 32'd0, got);
    check_val("lw_0x10", got, 32'h4);
    run_op(0, 1, 2'd0, 0, 32'h11, 32'hAB, got);
    check_val("sb_testmem", o_tm[0], 32'h0000AB04);
    run_op(1, 0, 2'd0, 1, 32'h11, 32'd0, got);
    check_val("lbu_0x11", got, 32'h0000_00AB);
    run_op(1, 0, 2'd0, 0, 32'h11, 32'd0, got);
    check_val("lb_0x11", got, 32'hFFFF_FFAB);
    idle(2);

    // MEM_LAT = 3 instance
    sel = 1;
    run_op(1, 0, 2'd2, 0, 32'h0C, 32'd0, got);
    check_val("lw_lat3", got, 32'h3);
    run_op(0, 0, 2'd2, 0, 32'h55, 32'd0, got);
    check_val("add_after_lw", got, 32'h55);
    run_op(1, 0, 2'd1, 0, 32'h13, 32'd0, got);
    check_val("lh_misal_res", got, 32'h0);
    check_val("lh_misal_err", o_err[1], 1);
    run_op(0, 1, 2'd2, 0, 32'h22, 32'hCAFE_F00D, got);
    check_val("sw_misal_err", o_err[1], 1);
    check_val("word4_kept", o_tm[1], 32'h4);
    run_op(1, 0, 2'd2, 0, 32'h20, 32'd0, got);
    check_val("word8_kept", got, 32'h8);

    // MEM_LAT = 4 instance: reset while a store is pending
    sel = 2;
    @(negedge clk);
    ex_valid = 1'b1; ex_rd = 1'b0; ex_wr = 1'b1; ex_size = 2'd2; ex_uns = 1'b0;
    ex_alu = 32'h10; ex_sd = 32'hDEAD_BEEF;
    repeat (2) begin
      @(posedge clk); #1;
      check_val("pend_stall", o_stall[2], 1);
    end
    #3;
    rst_n = 1'b0;
    ex_valid = 1'b0;
    #1;
    check_reset_outputs(2);
    check_val("pend_testmem", o_tm[2], 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    clear_last();
    idle(3);
    check_val("pend_dropped", o_tm[2], 32'h4);
    run_op(1, 0, 2'd2, 0, 32'h10, 32'd0, got);
    check_val("lw_after_rst", got, 32'h4);

    // Randomized traffic on every instance
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int n = 0; n < 50; n++) begin
        kind = int'($urandom_range(0, 9));
        rd   = (kind >= 3 && kind <= 5) || kind == 9;
        wr   = (kind >= 6 && kind <= 8) || kind == 9;
        addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
        run_op(rd, wr, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
               addr, $urandom, got);
        idle(int'($urandom_range(0, 2)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
